// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with a per-register pending ("busy") scoreboard.
//
// Two write ports, two combinational read ports, and one allocation port.
// Allocation marks a destination register as pending. A committed write clears
// the pending mark. busy_cnt is a registered population count of pending registers.
//
// Ports
//   clk                     rising-edge clock
//   rst                     synchronous, active-high reset
//   we0/waddr0/wdata0       write port 0
//   we1/waddr1/wdata1       write port 1; wins over port 0 on the same address
//   raddr0/raddr1           read addresses
//   rdata0/rdata1           read data (combinational)
//   busy0/busy1             pending flag of the register being read
//   alloc_v/alloc_addr      mark alloc_addr pending on this edge
//   busy_cnt                number of pending registers
//
// Parameters
//   DATA_W    register width
//   ADDR_W    address width; depth is 2**ADDR_W
//   ZERO_REG  when 1, register 0 reads as zero and ignores writes and allocs
//
// Optional feature: define RF_BYPASS_EN to forward same-cycle write data, and
// the cleared busy flag, to the read ports.
module regfile_mp #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [ADDR_W-1:0] raddr0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  input  logic              alloc_v,
  input  logic [ADDR_W-1:0] alloc_addr,
  output logic              busy0,
  output logic              busy1,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_nxt;
  logic [ADDR_W:0]   cnt_nxt;
  logic              wr0_ok;
  logic              wr1_ok;
  logic              alloc_ok;
  logic              zero0;
  logic              zero1;

  // Address 0 is hardwired when ZERO_REG is set, so it never takes a write or an alloc.
  assign wr0_ok   = we0     && !((ZERO_REG != 0) && (waddr0 == '0));
  assign wr1_ok   = we1     && !((ZERO_REG != 0) && (waddr1 == '0));
  assign alloc_ok = alloc_v && !((ZERO_REG != 0) && (alloc_addr == '0));
  assign zero0    = (ZERO_REG != 0) && (raddr0 == '0);
  assign zero1    = (ZERO_REG != 0) && (raddr1 == '0);

  // Writes clear first, then the alloc sets. An alloc in the same cycle as a
  // write is the newer event, so the register ends up pending.
  always_comb begin
    busy_nxt = busy_q;
    if (wr0_ok)   busy_nxt[waddr0]     = 1'b0;
    if (wr1_ok)   busy_nxt[waddr1]     = 1'b0;
    if (alloc_ok) busy_nxt[alloc_addr] = 1'b1;
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy_q   <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr0_ok) mem[waddr0] <= wdata0;
      // Port 1 is assigned last, so it overrides port 0 when both ports target the same address.
      if (wr1_ok) mem[waddr1] <= wdata1;
      busy_q   <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    rdata0 = mem[raddr0];
    busy0  = busy_q[raddr0];
    rdata1 = mem[raddr1];
    busy1  = busy_q[raddr1];
`ifdef RF_BYPASS_EN
    // A write that reset is about to discard is not forwarded.
    if (!rst) begin
      if (wr1_ok && (waddr1 == raddr0)) begin
        rdata0 = wdata1;
        busy0  = alloc_ok && (alloc_addr == raddr0);
      end else if (wr0_ok && (waddr0 == raddr0)) begin
        rdata0 = wdata0;
        busy0  = alloc_ok && (alloc_addr == raddr0);
      end
      if (wr1_ok && (waddr1 == raddr1)) begin
        rdata1 = wdata1;
        busy1  = alloc_ok && (alloc_addr == raddr1);
      end else if (wr0_ok && (waddr0 == raddr1)) begin
        rdata1 = wdata0;
        busy1  = alloc_ok && (alloc_addr == raddr1);
      end
    end
`else
`endif
    if (zero0) begin
      rdata0 = '0;
      busy0  = 1'b0;
    end
    if (zero1) begin
      rdata1 = '0;
      busy1  = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int D  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          we0, we1, alloc_v;
  logic [AW-1:0] waddr0, waddr1, raddr0, raddr1, alloc_addr;
  logic [DW-1:0] wdata0, wdata1;

  logic [DW-1:0] rd0_a, rd1_a, rd0_z, rd1_z;
  logic          bz0_a, bz1_a, bz0_z, bz1_z;
  logic [AW:0]   cnt_a, cnt_z;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) dut (
    .clk(clk), .rst(rst),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr0(raddr0), .raddr1(raddr1),
    .rdata0(rd0_a), .rdata1(rd1_a),
    .alloc_v(alloc_v), .alloc_addr(alloc_addr),
    .busy0(bz0_a), .busy1(bz1_a), .busy_cnt(cnt_a)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr0(raddr0), .raddr1(raddr1),
    .rdata0(rd0_z), .rdata1(rd1_z),
    .alloc_v(alloc_v), .alloc_addr(alloc_addr),
    .busy0(bz0_z), .busy1(bz1_z), .busy_cnt(cnt_z)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: index 0 is the plain file, index 1 has register 0 hardwired to zero.
  logic [DW-1:0] m [2][D];
  bit            b [2][D];

  function automatic bit writable(int z, logic [AW-1:0] a);
    return !(z == 1 && a == 0);
  endfunction

  function automatic logic [DW-1:0] exp_rd(int z, logic [AW-1:0] a);
    if (!writable(z, a)) return '0;
`ifdef RF_BYPASS_EN
    if (!rst && we1 && waddr1 == a) return wdata1;
    if (!rst && we0 && waddr0 == a) return wdata0;
`endif
    return m[z][a];
  endfunction

  function automatic bit exp_bz(int z, logic [AW-1:0] a);
    if (!writable(z, a)) return 1'b0;
`ifdef RF_BYPASS_EN
    if (!rst && ((we1 && waddr1 == a) || (we0 && waddr0 == a)))
      return alloc_v && alloc_addr == a;
`endif
    return b[z][a];
  endfunction

  function automatic int exp_cnt(int z);
    int s = 0;
    for (int i = 0; i < D; i++) s += int'(b[z][i]);
    return s;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("rdata0_a", 32'(rd0_a), 32'(exp_rd(0, raddr0)));
    chk("rdata1_a", 32'(rd1_a), 32'(exp_rd(0, raddr1)));
    chk("busy0_a",  32'(bz0_a), 32'(exp_bz(0, raddr0)));
    chk("busy1_a",  32'(bz1_a), 32'(exp_bz(0, raddr1)));
    chk("cnt_a",    32'(cnt_a), 32'(exp_cnt(0)));
    chk("rdata0_z", 32'(rd0_z), 32'(exp_rd(1, raddr0)));
    chk("rdata1_z", 32'(rd1_z), 32'(exp_rd(1, raddr1)));
    chk("busy0_z",  32'(bz0_z), 32'(exp_bz(1, raddr0)));
    chk("busy1_z",  32'(bz1_z), 32'(exp_bz(1, raddr1)));
    chk("cnt_z",    32'(cnt_z), 32'(exp_cnt(1)));
  endtask

  task automatic model_edge();
    for (int z = 0; z < 2; z++) begin
      if (rst) begin
        for (int i = 0; i < D; i++) begin
          m[z][i] = '0;
          b[z][i] = 1'b0;
        end
      end else begin
        if (we0 && writable(z, waddr0)) begin m[z][waddr0] = wdata0; b[z][waddr0] = 1'b0; end
        if (we1 && writable(z, waddr1)) begin m[z][waddr1] = wdata1; b[z][waddr1] = 1'b0; end
        if (alloc_v && writable(z, alloc_addr)) b[z][alloc_addr] = 1'b1;
      end
    end
  endtask

  task automatic idle();
    rst = 1'b0; we0 = 1'b0; we1 = 1'b0; alloc_v = 1'b0;
    waddr0 = '0; waddr1 = '0; alloc_addr = '0;
    wdata0 = '0; wdata1 = '0;
  endtask

  // Called just after a falling edge with inputs set: check, take the edge, update model.
  task automatic step();
    #1 check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    idle();
  endtask

  int cnt_before;

  initial begin
    idle();
    raddr0 = '0; raddr1 = '0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    idle();

    // Reset state at every address.
    for (int a = 0; a < D; a++) begin
      raddr0 = AW'(a);
      raddr1 = AW'(D - 1 - a);
      #1;
      chk("rst_rdata", 32'(rd0_a), 32'h0);
      chk("rst_busy",  32'(bz0_a), 32'h0);
      chk("rst_cnt",   32'(cnt_a), 32'h0);
      step();
    end

    // Read-during-write on address 2.
    raddr0 = 3'd2;
    we0 = 1'b1; waddr0 = 3'd2; wdata0 = 16'hA5A5;
    #1;
`ifdef RF_BYPASS_EN
    chk("rdw_same", 32'(rd0_a), 32'hA5A5);
`else
    chk("rdw_same", 32'(rd0_a), 32'h0);
`endif
    step();
    #1 chk("rdw_next", 32'(rd0_a), 32'hA5A5);

    // Both ports to address 3: port 1 wins.
    we0 = 1'b1; waddr0 = 3'd3; wdata0 = 16'h1111;
    we1 = 1'b1; waddr1 = 3'd3; wdata1 = 16'h2222;
    step();
    raddr0 = 3'd3;
    #1 chk("dual_wr", 32'(rd0_a), 32'h2222);
    step();

    // Alloc then write clears pending.
    alloc_v = 1'b1; alloc_addr = 3'd5;
    step();
    raddr0 = 3'd5;
    #1;
    chk("alloc_busy", 32'(bz0_a), 32'h1);
    chk("alloc_cnt",  32'(cnt_a), 32'h1);
    we0 = 1'b1; waddr0 = 3'd5; wdata0 = 16'hBEEF;
    step();
    #1;
    chk("wr_clr_busy", 32'(bz0_a), 32'h0);
    chk("wr_clr_cnt",  32'(cnt_a), 32'h0);
    chk("wr_clr_data", 32'(rd0_a), 32'hBEEF);

    // Hardwired zero register.
    cnt_before = int'(cnt_z);
    we0 = 1'b1; waddr0 = 3'd0; wdata0 = 16'hFFFF;
    alloc_v = 1'b1; alloc_addr = 3'd0;
    raddr0 = 3'd0;
    step();
    #1;
    chk("zr_rdata", 32'(rd0_z), 32'h0);
    chk("zr_busy",  32'(bz0_z), 32'h0);
    chk("zr_cnt",   32'(cnt_z), 32'(cnt_before));
    chk("nz_rdata", 32'(rd0_a), 32'hFFFF);

    // Reset with pending registers and a concurrent write.
    alloc_v = 1'b1; alloc_addr = 3'd1; step();
    alloc_v = 1'b1; alloc_addr = 3'd2; step();
    alloc_v = 1'b1; alloc_addr = 3'd3; step();
    #1 chk("pend_cnt", 32'(cnt_a), 32'h4);
    rst = 1'b1; we0 = 1'b1; waddr0 = 3'd1; wdata0 = 16'h1234;
    step();
    for (int a = 0; a < D; a++) begin
      raddr0 = AW'(a);
      #1;
      chk("rst2_rdata", 32'(rd0_a), 32'h0);
      chk("rst2_busy",  32'(bz0_a), 32'h0);
      chk("rst2_cnt",   32'(cnt_a), 32'h0);
      step();
    end

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      rst        = ($urandom_range(0, 59) == 0);
      we0        = $urandom_range(0, 1) == 1;
      we1        = $urandom_range(0, 2) == 0;
      alloc_v    = $urandom_range(0, 1) == 1;
      waddr0     = AW'($urandom_range(0, D - 1));
      waddr1     = AW'($urandom_range(0, D - 1));
      alloc_addr = AW'($urandom_range(0, D - 1));
      raddr0     = AW'($urandom_range(0, D - 1));
      raddr1     = ($urandom_range(0, 1) == 1) ? waddr0 : AW'($urandom_range(0, D - 1));
      wdata0     = DW'($urandom);
      wdata1     = DW'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
